// File: rtl/ram_cmd_arbiter_if.sv
// Requester-side word transaction port of ram_cmd_arbiter.
// The master drives req/we/addr/wdata and receives ack/rdata/err.
interface ram_cmd_arbiter_if #(
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 8
);
  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] wdata;
  logic                 ack;
  logic [WORD_SIZE-1:0] rdata;
  logic                 err;

  modport master (output req, we, addr, wdata, input  ack, rdata, err);
  modport slave  (input  req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter for two requesters sharing the single-port command RAM.
// Each transaction becomes a set-address command followed by a write or read command.
module ram_cmd_arbiter #(
  parameter int ADDR_SIZE  = 8,
  parameter int WORD_SIZE  = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_cmd_arbiter_if.slave     m0,
  ram_cmd_arbiter_if.slave     m1,
  output logic                 ram_rx_valid,
  output logic [WORD_SIZE+1:0] ram_din,
  input  logic                 ram_tx_valid,
  input  logic [WORD_SIZE-1:0] ram_dout
);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  localparam logic [1:0] OP_SET_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_SET_RADDR = 2'b10;
  localparam logic [1:0] OP_READ      = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_OP, S_RWAIT, S_DONE} state_e;

  state_e                 state_q;
  logic                   gnt_q;
  logic                   last_grant_q;
  logic                   we_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rx_valid_q;
  logic [WORD_SIZE+1:0]   din_q;
  logic                   m0_ack_q, m1_ack_q;
  logic                   m0_err_q, m1_err_q;
  logic [WORD_SIZE-1:0]   m0_rdata_q, m1_rdata_q;

  logic                   gnt_d;
  logic                   we_d;
  logic [ADDR_SIZE-1:0]   addr_d;
  logic [WORD_SIZE-1:0]   wdata_d;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt_d = m1.req;
    if (m0.req && m1.req) gnt_d = ~last_grant_q;
    we_d    = gnt_d ? m1.we    : m0.we;
    addr_d  = gnt_d ? m1.addr  : m0.addr;
    wdata_d = gnt_d ? m1.wdata : m0.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rx_valid_q   <= 1'b0;
      din_q        <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (m0.req || m1.req) begin
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rx_valid_q <= 1'b1;
            din_q      <= {(we_d ? OP_SET_WADDR : OP_SET_RADDR), WORD_SIZE'(addr_d)};
            state_q    <= S_ADDR;
          end
        end
        S_ADDR: begin
          rx_valid_q <= 1'b1;
          din_q      <= we_q ? {OP_WRITE, wdata_q} : {OP_READ, {WORD_SIZE{1'b0}}};
          state_q    <= S_OP;
        end
        S_OP: begin
          if (we_q) begin
            if (gnt_q) m1_ack_q <= 1'b1;
            else       m0_ack_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          // tx_valid was cleared by the set-read-address command, so any high here is fresh data.
          if (ram_tx_valid) begin
            if (gnt_q) begin m1_rdata_q <= ram_dout; m1_ack_q <= 1'b1; end
            else       begin m0_rdata_q <= ram_dout; m0_ack_q <= 1'b1; end
            state_q <= S_DONE;
          end else if (cnt_q == CNT_W'(RD_TIMEOUT)) begin
            if (gnt_q) begin m1_rdata_q <= '0; m1_ack_q <= 1'b1; m1_err_q <= 1'b1; end
            else       begin m0_rdata_q <= '0; m0_ack_q <= 1'b1; m0_err_q <= 1'b1; end
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          last_grant_q <= gnt_q;
          cnt_q        <= '0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_rx_valid = rx_valid_q;
  assign ram_din      = din_q;
  assign m0.ack       = m0_ack_q;
  assign m0.err       = m0_err_q;
  assign m0.rdata     = m0_rdata_q;
  assign m1.ack       = m1_ack_q;
  assign m1.err       = m1_err_q;
  assign m1.rdata     = m1_rdata_q;
endmodule
